// File: rtl/stream_async_fifo_pkt_if.sv
// rtl/stream_async_fifo_pkt_if.sv - write/read stream handshake bundle for the dual-clock FIFO
interface stream_async_fifo_pkt_if #(
  parameter int DSIZE = 8
);
  logic             itvalid;
  logic             itready;
  logic [DSIZE-1:0] itdata;
  logic             itlast;
  logic             otvalid;
  logic             otready;
  logic [DSIZE-1:0] otdata;
  logic             otlast;

  modport master (
    output itvalid, itdata, itlast, otready,
    input  itready, otvalid, otdata, otlast
  );

  modport slave (
    input  itvalid, itdata, itlast, otready,
    output itready, otvalid, otdata, otlast
  );
endinterface

// File: rtl/stream_async_fifo_pkt.sv
// rtl/stream_async_fifo_pkt.sv - dual-clock data+last stream FIFO with fill levels and flags
// Define STREAM_ASYNC_FIFO_PKT_MODE_EN for store-and-forward packet mode with oversize drop.
module stream_async_fifo_pkt #(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int AFULL_THRESH  = (1 << ASIZE) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                   iclk,
  input  logic                   irstn,
  input  logic                   oclk,
  input  logic                   orstn,
  stream_async_fifo_pkt_if.slave s,
  output logic [ASIZE:0]         iwlevel,
  output logic                   ialmost_full,
  output logic                   ipkt_drop,
  output logic [ASIZE:0]         orlevel,
  output logic                   oalmost_empty
);
  localparam int DEPTH = 1 << ASIZE;
  typedef logic [ASIZE:0] ptr_t;
  localparam ptr_t PTR_ONE    = ptr_t'(1);
  localparam ptr_t PTR_DEPTH  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THRESH);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DSIZE:0] mem_q [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wptr_q, wptr_d;
  ptr_t wpub;
  ptr_t wgray_q;
  ptr_t wlevel_q;
  ptr_t rsync_q [SYNC_STAGES];
  ptr_t rsync_gray, rsync_bin;
  logic full;
  logic wr_en;

  ptr_t rgray_q;

  assign rsync_gray = rsync_q[SYNC_STAGES-1];
  assign rsync_bin  = gray2bin(rsync_gray);
  // Full when the write pointer leads the synced read pointer by exactly one lap.
  assign full = (bin2gray(wptr_q) == {~rsync_gray[ASIZE:ASIZE-1], rsync_gray[ASIZE-2:0]});

`ifdef STREAM_ASYNC_FIFO_PKT_MODE_EN
  typedef enum logic {PASS = 1'b0, DROP = 1'b1} wstate_t;
  wstate_t state_q, state_d;
  ptr_t    wcommit_q, wcommit_d;
  logic    oversize;

  assign oversize = full && ((wptr_q - wcommit_q) == PTR_DEPTH);

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state_q   <= PASS;
      wcommit_q <= '0;
    end else begin
      state_q   <= state_d;
      wcommit_q <= wcommit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS:    if (oversize) state_d = DROP;
      DROP:    if (s.itvalid && s.itready && s.itlast) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    s.itready = 1'b0;
    ipkt_drop = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      PASS: begin
        s.itready = ~full & irstn;
        ipkt_drop = oversize;
        wr_en     = s.itvalid & s.itready;
      end
      DROP:    s.itready = irstn;
      default: s.itready = 1'b0;
    endcase
  end

  // Only the commit pointer is published, so the reader sees whole packets.
  always_comb begin
    wptr_d    = wptr_q;
    wcommit_d = wcommit_q;
    if (ipkt_drop) begin
      wptr_d = wcommit_q;
    end else if (wr_en) begin
      wptr_d = wptr_q + PTR_ONE;
      if (s.itlast) wcommit_d = wptr_q + PTR_ONE;
    end
  end

  assign wpub = wcommit_q;
`else
  assign s.itready = ~full & irstn;
  assign wr_en     = s.itvalid & s.itready;
  assign ipkt_drop = 1'b0;
  assign wptr_d    = wr_en ? (wptr_q + PTR_ONE) : wptr_q;
  assign wpub      = wptr_q;
`endif

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      wptr_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      wgray_q    <= bin2gray(wpub);
      wlevel_q   <= wptr_q - rsync_bin;
      rsync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_en) mem_q[wptr_q[ASIZE-1:0]] <= {s.itlast, s.itdata};
  end

  assign iwlevel      = wlevel_q;
  assign ialmost_full = (wlevel_q >= AFULL_LVL);

  // ---------------- read domain ----------------
  ptr_t             rptr_q, rptr_d;
  ptr_t             rlevel_q;
  ptr_t             wsync_q [SYNC_STAGES];
  ptr_t             wsync_gray, wsync_bin;
  logic             empty;
  logic             pop;
  logic             otvalid_q;
  logic [DSIZE-1:0] otdata_q;
  logic             otlast_q;

  assign wsync_gray = wsync_q[SYNC_STAGES-1];
  assign wsync_bin  = gray2bin(wsync_gray);
  assign empty      = (bin2gray(rptr_q) == wsync_gray);
  // Refill the output register whenever it is empty or being drained this cycle.
  assign pop        = ~empty & (~otvalid_q | s.otready);
  assign rptr_d     = pop ? (rptr_q + PTR_ONE) : rptr_q;

  always_ff @(posedge oclk or negedge orstn) begin
    if (!orstn) begin
      rptr_q    <= '0;
      rgray_q   <= '0;
      rlevel_q  <= '0;
      otvalid_q <= 1'b0;
      otdata_q  <= '0;
      otlast_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
    end else begin
      rptr_q     <= rptr_d;
      rgray_q    <= bin2gray(rptr_q);
      rlevel_q   <= wsync_bin - rptr_q;
      wsync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
      if (pop) begin
        {otlast_q, otdata_q} <= mem_q[rptr_q[ASIZE-1:0]];
        otvalid_q            <= 1'b1;
      end else if (s.otready) begin
        otvalid_q <= 1'b0;
      end
    end
  end

  assign s.otvalid     = otvalid_q;
  assign s.otdata      = otdata_q;
  assign s.otlast      = otlast_q;
  assign orlevel       = rlevel_q;
  assign oalmost_empty = (rlevel_q <= AEMPTY_LVL);
endmodule

// File: tb/tb_stream_async_fifo_pkt.sv
// tb/tb_stream_async_fifo_pkt.sv - randomized bench with queue-based reference model
`timescale 1ns/1ps
module tb_stream_async_fifo_pkt;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic iclk = 1'b0, oclk = 1'b0, irstn = 1'b0, orstn = 1'b0;
  logic [ASIZE:0] iwlevel, orlevel;
  logic ialmost_full, ipkt_drop, oalmost_empty;

  stream_async_fifo_pkt_if #(.DSIZE(DSIZE)) bus ();

  stream_async_fifo_pkt #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .SYNC_STAGES(2),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .iclk(iclk), .irstn(irstn), .oclk(oclk), .orstn(orstn), .s(bus),
    .iwlevel(iwlevel), .ialmost_full(ialmost_full), .ipkt_drop(ipkt_drop),
    .orlevel(orlevel), .oalmost_empty(oalmost_empty)
  );

  always #5 iclk = ~iclk;
  always #8.333 oclk = ~oclk;

  int checks = 0, errors = 0;
  logic [DSIZE:0] exp_q[$];
  logic [DSIZE:0] pend_q[$];
  logic [DSIZE:0] out_log[$];
  bit   drop_mode = 0;
  int   exp_drops = 0, seen_drops = 0, delivered = 0, pushed = 0;
  int   run_cur = 0, run_max = 0;
  int   rd_mode = 0;
  bit   stall_prev = 0;
  logic [DSIZE+1:0] stall_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats become visible individually, or per whole packet in packet mode.
  task automatic model_write(input logic [DSIZE:0] b);
`ifdef STREAM_ASYNC_FIFO_PKT_MODE_EN
    if (drop_mode) begin
      if (b[DSIZE]) drop_mode = 0;
    end else begin
      pend_q.push_back(b);
      if (b[DSIZE]) begin
        foreach (pend_q[i]) begin exp_q.push_back(pend_q[i]); pushed++; end
        pend_q.delete();
      end else if (pend_q.size() == DEPTH) begin
        pend_q.delete();
        drop_mode = 1;
        exp_drops++;
      end
    end
`else
    exp_q.push_back(b);
    pushed++;
`endif
  endtask

  always @(negedge iclk) begin
    if (!irstn) begin
      chk("rst_itready", bus.itready, 0);
      chk("rst_iwlevel", iwlevel, 0);
      chk("rst_ialmost_full", ialmost_full, 0);
      chk("rst_ipkt_drop", ipkt_drop, 0);
    end else begin
      chk("ialmost_full_rule", ialmost_full, (iwlevel >= AF));
      chk("iwlevel_max", (iwlevel <= DEPTH), 1);
      if (ipkt_drop) seen_drops++;
      if (bus.itvalid && bus.itready) model_write({bus.itlast, bus.itdata});
    end
  end

  always @(negedge oclk) begin
    if (!orstn) begin
      chk("rst_otvalid", bus.otvalid, 0);
      chk("rst_oalmost_empty", oalmost_empty, 1);
      stall_prev = 0;
      run_cur = 0;
    end else begin
      chk("orlevel_max", (orlevel <= DEPTH), 1);
      chk("oalmost_empty_rule", oalmost_empty, (orlevel <= AE));
      if (stall_prev) chk("stall_hold", {bus.otvalid, bus.otlast, bus.otdata}, stall_val);
      if (bus.otvalid) begin
        chk("beat_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("otdata", {bus.otlast, bus.otdata}, exp_q[0]);
        if (bus.otready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          out_log.push_back({bus.otlast, bus.otdata});
          delivered++;
          run_cur++;
        end else run_cur = 0;
      end else run_cur = 0;
      if (run_cur > run_max) run_max = run_cur;
      stall_prev = bus.otvalid & ~bus.otready;
      stall_val  = {1'b1, bus.otlast, bus.otdata};
    end
  end

  initial begin
    bus.otready = 1'b0;
    forever begin
      @(posedge oclk); #1;
      case (rd_mode)
        0:       bus.otready = 1'b0;
        1:       bus.otready = 1'b1;
        default: bus.otready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [DSIZE-1:0] d, input logic l);
    int n = 0;
    bit ok = 0;
    bus.itvalid = 1'b1; bus.itdata = d; bus.itlast = l;
    while (!ok && n < 2000) begin
      @(negedge iclk); ok = bus.itready;
      @(posedge iclk); #1;
      n++;
    end
    bus.itvalid = 1'b0;
    if (!ok) chk("send_timeout", n, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.otvalid) && n < 4000) begin @(negedge oclk); n++; end
    chk(name, (n < 4000), 1);
    idle(12);
  endtask

  task automatic assert_rst();
    irstn = 1'b0; orstn = 1'b0;
    #1;
    exp_q.delete(); pend_q.delete(); drop_mode = 0;
    repeat (4) @(posedge oclk);
  endtask

  task automatic release_rst(input bit hold_read);
    @(posedge iclk); #1 irstn = 1'b1;
    if (!hold_read) begin @(posedge oclk); #1 orstn = 1'b1; end
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, p0;
    bus.itvalid = 1'b0; bus.itdata = '0; bus.itlast = 1'b0;
    assert_rst();
    release_rst(0);
    @(negedge iclk);
    chk("init_itready", bus.itready, 1);
    chk("init_iwlevel", iwlevel, 0);
    chk("init_otvalid", bus.otvalid, 0);
    chk("init_oalmost_empty", oalmost_empty, 1);
    idle(1);

    // Test 1: five beats in order, last flag only on beat 5
    rd_mode = 1; base = out_log.size();
    for (int i = 1; i <= 5; i++) send(DSIZE'(i), (i == 5));
    drain("t1_drain");
    chk("t1_count", out_log.size() - base, 5);
    if (out_log.size() >= base + 5) begin
      chk("t1_first", out_log[base], 9'h001);
      chk("t1_last", out_log[base+4], 9'h105);
    end
    chk("t1_iwlevel", iwlevel, 0);
    chk("t1_orlevel", orlevel, 0);

`ifndef STREAM_ASYNC_FIFO_PKT_MODE_EN
    // Test 2: fill to capacity with the reader held, then release
    rd_mode = 0;
    assert_rst();
    release_rst(1);
    base = out_log.size();
    for (int i = 0; i < 16; i++) send(DSIZE'(8'h20 + i), 1'b0);
    idle(10);
    @(negedge iclk);
    chk("t2_itready_full", bus.itready, 0);
    chk("t2_iwlevel", iwlevel, 16);
    chk("t2_ialmost_full", ialmost_full, 1);
    idle(1);
    @(posedge oclk); #1 orstn = 1'b1;
    rd_mode = 1;
    for (int i = 16; i < 20; i++) send(DSIZE'(8'h20 + i), (i == 19));
    drain("t2_drain");
    chk("t2_count", out_log.size() - base, 20);
`endif

    // Test 3: random traffic over many pointer wraps with random stalls
    assert_rst();
    release_rst(0);
    rd_mode = 2; d0 = delivered; p0 = pushed;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(DSIZE'($urandom), ((i == 399) || ($urandom_range(0, 5) == 0)));
    end
    drain("t3_drain");
    chk("t3_count", delivered - d0, pushed - p0);
`ifndef STREAM_ASYNC_FIFO_PKT_MODE_EN
    chk("t3_pushed", pushed - p0, 400);
`endif

    // Test 4: mid-stream flush with 7 beats stored
    rd_mode = 0;
    for (int i = 0; i < 7; i++) send(DSIZE'(8'h60 + i), (i == 6));
    idle(30);
    chk("t4_iwlevel_pre", iwlevel, 6);
    chk("t4_orlevel_pre", orlevel, 6);
    chk("t4_otvalid_pre", bus.otvalid, 1);
    assert_rst();
    @(negedge iclk);
    chk("t4_otvalid", bus.otvalid, 0);
    chk("t4_iwlevel", iwlevel, 0);
    chk("t4_orlevel", orlevel, 0);
    chk("t4_oalmost_empty", oalmost_empty, 1);
    release_rst(0);
    rd_mode = 1; base = out_log.size();
    send(8'hA5, 1'b1);
    drain("t4_drain");
    chk("t4_count", out_log.size() - base, 1);
    if (out_log.size() > base) chk("t4_first", out_log[base], 9'h1A5);

`ifdef STREAM_ASYNC_FIFO_PKT_MODE_EN
    // Test 5: packet held back until its last beat commits
    run_max = 0; base = out_log.size();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge iclk); chk("t5_hold", bus.otvalid, 0);
    end
    idle(1);
    send(8'h33, 1'b1);
    drain("t5_drain");
    chk("t5_count", out_log.size() - base, 3);
    chk("t5_b2b", (run_max >= 3), 1);

    // Test 6: oversize packet dropped, following short packet delivered
    d0 = seen_drops; base = out_log.size();
    for (int i = 0; i < 20; i++) send(DSIZE'(8'h40 + i), (i == 19));
    send(8'h71, 1'b0);
    send(8'h72, 1'b1);
    drain("t6_drain");
    chk("t6_drops", seen_drops - d0, 1);
    chk("t6_count", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      chk("t6_b0", out_log[base], 9'h071);
      chk("t6_b1", out_log[base+1], 9'h172);
    end
`endif

    chk("drop_total", seen_drops, exp_drops);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
